// File: rtl/ides_word_aligner_pkg.sv
// ---------------------------------------------------------------------------
// ides_align_pkg
//   Shared definitions for the IDES word aligner: FSM state encoding,
//   default training patterns and a word-rotation helper used when
//   reasoning about how bitslips move the training word.
// ---------------------------------------------------------------------------
package ides_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4
  } align_state_e;

  // Default training words; both differ from every one of their rotations.
  localparam logic [15:0] PATTERN_W16 = 16'h00FF;
  localparam logic [7:0]  PATTERN_W8  = 8'h0F;

  // Settle counter width (supports SETTLE_CYCLES up to 255).
  localparam int unsigned SETTLE_W = 32'd8;

  // Rotate the low 'width' bits (8 or 16) of w right by amt positions.
  function automatic logic [15:0] rotr(input logic [15:0] w,
                                       input int unsigned amt,
                                       input int unsigned width);
    logic [15:0] res;
    if (width == 32'd8) begin
      res = {8'h00, 8'(({w[7:0], w[7:0]}) >> amt[2:0])};
    end else begin
      res = 16'(({w, w}) >> amt[3:0]);
    end
    return res;
  endfunction

endpackage

// File: rtl/ides_word_aligner_if.sv
// ---------------------------------------------------------------------------
// ides_word_aligner_if
//   Bundles the aligner's deserializer-facing and consumer-facing signals.
//   slave  : the aligner (inputs en_i/relock_i/q_i, drives the rest)
//   master : the environment (drives en_i/relock_i/q_i, observes the rest)
//   Signals: en_i, relock_i, q_i[WIDTH], calib_o, locked_o, word_o[WIDTH],
//            word_valid_o, slip_cnt_o[clog2(WIDTH)], wrap_o
// ---------------------------------------------------------------------------
interface ides_word_aligner_if #(
  parameter int unsigned WIDTH = 32'd16
);
  localparam int unsigned SW = $clog2(WIDTH);

  logic             en_i;
  logic             relock_i;
  logic [WIDTH-1:0] q_i;
  logic             calib_o;
  logic             locked_o;
  logic [WIDTH-1:0] word_o;
  logic             word_valid_o;
  logic [SW-1:0]    slip_cnt_o;
  logic             wrap_o;

  modport master (
    output en_i, relock_i, q_i,
    input  calib_o, locked_o, word_o, word_valid_o, slip_cnt_o, wrap_o
  );

  modport slave (
    input  en_i, relock_i, q_i,
    output calib_o, locked_o, word_o, word_valid_o, slip_cnt_o, wrap_o
  );

endinterface

// File: rtl/ides_word_aligner_pattern_match.sv
// ---------------------------------------------------------------------------
// ides_pattern_match
//   Compares each parallel word against the training pattern and counts
//   consecutive matches (saturating at LOCK_COUNT).
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : zero the match counter
//   cmp_en_i   : compare/count this cycle
//   q_i        : word under test
//   match_o    : q_i equals the pattern (combinational)
//   hit_o      : pulse on the compare that brings the count to LOCK_COUNT
// ---------------------------------------------------------------------------
module ides_pattern_match
  import ides_align_pkg::*;
#(
  parameter int unsigned WIDTH      = 32'd16,
  parameter logic [15:0] PATTERN    = PATTERN_W16,
  parameter int unsigned LOCK_COUNT = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             cmp_en_i,
  input  logic [WIDTH-1:0] q_i,
  output logic             match_o,
  output logic             hit_o
);

  localparam logic [3:0] CNT_MAX = 4'(LOCK_COUNT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Pattern compare and next consecutive-match count.
  always_comb begin
    match_o = (q_i == PATTERN[WIDTH-1:0]);
    hit_o   = 1'b0;
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = 4'd0;
    end else if (cmp_en_i) begin
      if (match_o) begin
        // Saturate so a held count never re-fires the hit pulse.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = cnt_q;
        end
        hit_o = ((cnt_q + 4'd1) == CNT_MAX);
      end else begin
        cnt_d = 4'd0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Match counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ides_word_aligner.sv
// ---------------------------------------------------------------------------
// ides_word_aligner
//   PCLK-domain word aligner for the IDES16 deserializer. Searches for the
//   training pattern, issuing single-cycle CALIB (bitslip) pulses with a
//   settle gap after each, and once LOCK_COUNT consecutive matches are seen
//   forwards registered data words with a valid flag and lock indicator.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ides_word_aligner_if.slave (en_i, relock_i, q_i in;
//              calib_o, locked_o, word_o, word_valid_o, slip_cnt_o, wrap_o out)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module ides_word_aligner
  import ides_align_pkg::*;
#(
  parameter int unsigned WIDTH         = 32'd16,
  parameter logic [15:0] PATTERN       = (WIDTH == 32'd8) ? {8'h00, PATTERN_W8} : PATTERN_W16,
  parameter int unsigned LOCK_COUNT    = 32'd4,
  parameter int unsigned SETTLE_CYCLES = 32'd3
) (
  input  logic              clk,
  input  logic              rst,
  ides_word_aligner_if.slave bus
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [SW-1:0]       SLIP_LAST   = SW'(WIDTH - 32'd1);

  align_state_e         state_q, state_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 calib_q, calib_d;
  logic                 locked_q, locked_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic                 valid_q, valid_d;
  logic [SW-1:0]        slip_q, slip_d;
  logic                 wrap_q, wrap_d;

  logic                 match_eq;
  logic                 match_hit;
  logic                 match_clear;
  logic                 match_cmp;

  // Counter is held at zero outside CHECK, so every CHECK entry starts fresh.
  assign match_clear = (state_q != ST_CHECK);
  assign match_cmp   = (state_q == ST_CHECK);

  ides_pattern_match #(
    .WIDTH      (WIDTH),
    .PATTERN    (PATTERN),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (match_clear),
    .cmp_en_i (match_cmp),
    .q_i      (bus.q_i),
    .match_o  (match_eq),
    .hit_o    (match_hit)
  );

  // Next-state logic; a low enable overrides everything, including relock.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (!bus.en_i) begin
      state_d  = ST_IDLE;
      settle_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (match_hit) begin
            state_d = ST_LOCKED;
          end else if (!match_eq) begin
            state_d = ST_SLIP;
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_SLIP: begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = ST_CHECK;
            settle_d = '0;
          end else begin
            settle_d = settle_q + SETTLE_W'(1);
          end
        end
        ST_LOCKED: begin
          if (bus.relock_i) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          settle_d = '0;
        end
      endcase
    end
  end

  // Output values for the cycle the FSM is about to enter, so outputs line
  // up with the state they describe while still coming straight from flops.
  always_comb begin
    calib_d  = (state_d == ST_SLIP);
    locked_d = (state_d == ST_LOCKED);
    valid_d  = (state_d == ST_LOCKED);
    wrap_d   = 1'b0;
    slip_d   = slip_q;
    if (state_d == ST_LOCKED) begin
      word_d = bus.q_i;
    end else begin
      word_d = '0;
    end
    if (state_d == ST_SLIP) begin
      slip_d = slip_q + SW'(1);
      wrap_d = (slip_q == SLIP_LAST);
    end else begin
      slip_d = slip_q;
      wrap_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      calib_q  <= 1'b0;
      locked_q <= 1'b0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      slip_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      calib_q  <= calib_d;
      locked_q <= locked_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      slip_q   <= slip_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.calib_o      = calib_q;
  assign bus.locked_o     = locked_q;
  assign bus.word_o       = word_q;
  assign bus.word_valid_o = valid_q;
  assign bus.slip_cnt_o   = slip_q;
  assign bus.wrap_o       = wrap_q;

endmodule

// File: tb/tb_ides_word_aligner.sv
// ---------------------------------------------------------------------------
// tb_ides_word_aligner
//   Drives the aligner from a deserializer model whose output is the
//   training word rotated by (k - slips) mod 16, where a slip takes effect
//   two cycles after each calib_o pulse. A negedge monitor checks slip
//   count/wrap/spacing and forwarded words against bench-side expectations.
// ---------------------------------------------------------------------------
module tb_ides_word_aligner;
  import ides_align_pkg::*;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned LOCK    = 4;
  localparam int unsigned SETTLE  = 3;
  localparam int          MIN_GAP = SETTLE + 2;
  localparam logic [15:0] PAT     = 16'h00FF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ides_word_aligner_if #(.WIDTH(WIDTH)) bus();

  ides_word_aligner #(
    .WIDTH(WIDTH), .PATTERN(PAT), .LOCK_COUNT(LOCK), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Deserializer model state.
  int          cyc = 0;
  int          k = 0;
  int          model_slips = 0;
  int          pend[$];
  bit          force_zero = 1'b0;
  bit          data_mode = 1'b0;
  bit          ovr_en = 1'b0;
  logic [15:0] ovr_word = 16'h0000;
  logic [15:0] drv_hist[$];

  // Monitor state.
  int pulse_cnt = 0;
  int wrap_cnt = 0;
  int mon_slip = 0;
  int mcyc = 0;
  int last_pulse = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance the deserializer model and drive the next word.
  task automatic tick();
    int amt;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      model_slips = 0;
      pend.delete();
    end else begin
      if (bus.calib_o === 1'b1) pend.push_back(cyc + 2);
      while (pend.size() > 0 && pend[0] <= cyc) begin
        void'(pend.pop_front());
        model_slips++;
      end
    end
    amt = (((k - model_slips) % 16) + 16) % 16;
    if (ovr_en)          bus.q_i = ovr_word;
    else if (force_zero) bus.q_i = 16'h0000;
    else if (data_mode)  bus.q_i = 16'($urandom);
    else                 bus.q_i = rotr(PAT, amt, WIDTH);
    drv_hist.push_back(bus.q_i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en_i = 1'b0;
    bus.relock_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_lock(input string name, output int ticks);
    ticks = 0;
    while (bus.locked_o !== 1'b1 && ticks < 400) begin
      tick();
      ticks++;
    end
    chk({name, "_locked"}, bus.locked_o, 1);
  endtask

  // Monitor: slip count, wrap, pulse spacing, forwarded data.
  always @(negedge clk) begin
    mcyc++;
    while (drv_hist.size() > 2) void'(drv_hist.pop_front());
    if (bus.calib_o === 1'b1) begin
      pulse_cnt++;
      mon_slip = (mon_slip + 1) % WIDTH;
      chk("wrap_on_calib", bus.wrap_o, (mon_slip == 0));
      if (last_pulse >= 0) chk("calib_gap", ((mcyc - last_pulse) >= MIN_GAP), 1);
      last_pulse = mcyc;
      if (bus.wrap_o === 1'b1) wrap_cnt++;
    end else begin
      chk("wrap_without_calib", bus.wrap_o, 0);
    end
    chk("slip_cnt", bus.slip_cnt_o, mon_slip);
    if (bus.word_valid_o === 1'b1) begin
      if (drv_hist.size() == 2) chk("word_o", bus.word_o, drv_hist[0]);
      else chk("word_hist_avail", drv_hist.size(), 2);
    end
    if (rst) begin
      mon_slip = 0;
      last_pulse = -1;
    end
  end

  initial begin
    int t;
    int p0;
    int w0;
    int n;
    bit saw_lock;

    bus.en_i = 1'b0;
    bus.relock_i = 1'b0;
    bus.q_i = 16'h0000;

    // Reset values.
    do_reset();
    chk("rst_calib", bus.calib_o, 0);
    chk("rst_locked", bus.locked_o, 0);
    chk("rst_valid", bus.word_valid_o, 0);
    chk("rst_wrap", bus.wrap_o, 0);
    chk("rst_slip", bus.slip_cnt_o, 0);
    chk("rst_word", bus.word_o, 0);

    // Aligned start: lock with no slips on the 5th cycle.
    k = 0;
    p0 = pulse_cnt;
    bus.en_i = 1'b1;
    wait_lock("aligned", t);
    chk("aligned_lock_cycle", t, 5);
    chk("aligned_pulses", pulse_cnt - p0, 0);
    chk("aligned_slip", bus.slip_cnt_o, 0);
    data_mode = 1'b1;
    repeat (20) tick();
    ovr_en = 1'b1;
    ovr_word = 16'hA5C3;
    tick();
    ovr_en = 1'b0;
    tick();
    chk("word_A5C3", bus.word_o, 16'hA5C3);
    chk("lock_held_on_data", bus.locked_o, 1);
    data_mode = 1'b0;

    // Offset k=3: three slips, then lock.
    do_reset();
    k = 3;
    p0 = pulse_cnt;
    bus.en_i = 1'b1;
    wait_lock("k3", t);
    chk("k3_pulses", pulse_cnt - p0, 3);
    chk("k3_slip", bus.slip_cnt_o, 3);
    data_mode = 1'b1;
    repeat (12) tick();
    data_mode = 1'b0;

    // No pattern: continuous slipping, one wrap after 16 slips, no lock.
    do_reset();
    force_zero = 1'b1;
    p0 = pulse_cnt;
    w0 = wrap_cnt;
    saw_lock = 1'b0;
    n = 0;
    bus.en_i = 1'b1;
    while ((pulse_cnt - p0) < 16 && n < 400) begin
      tick();
      n++;
      if (bus.locked_o === 1'b1) saw_lock = 1'b1;
    end
    chk("zero_pulses", pulse_cnt - p0, 16);
    chk("zero_wraps", wrap_cnt - w0, 1);
    chk("zero_slip_back", bus.slip_cnt_o, 0);
    chk("zero_never_locked", saw_lock, 0);
    force_zero = 1'b0;

    // Reset during SETTLE after two slips.
    do_reset();
    k = 5;
    p0 = pulse_cnt;
    n = 0;
    bus.en_i = 1'b1;
    while ((pulse_cnt - p0) < 2 && n < 200) begin
      tick();
      n++;
    end
    chk("settle_two_pulses", pulse_cnt - p0, 2);
    rst = 1'b1;
    bus.en_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_calib", bus.calib_o, 0);
    chk("midrst_locked", bus.locked_o, 0);
    chk("midrst_valid", bus.word_valid_o, 0);
    chk("midrst_wrap", bus.wrap_o, 0);
    chk("midrst_slip", bus.slip_cnt_o, 0);
    chk("midrst_word", bus.word_o, 0);
    p0 = pulse_cnt;
    repeat (10) tick();
    chk("midrst_no_calib", pulse_cnt - p0, 0);

    // Relock after the deserializer shifts by one.
    do_reset();
    k = 0;
    bus.en_i = 1'b1;
    wait_lock("pre_relock", t);
    repeat (3) tick();
    k = 1;
    p0 = pulse_cnt;
    bus.relock_i = 1'b1;
    tick();
    bus.relock_i = 1'b0;
    chk("relock_locked_drop", bus.locked_o, 0);
    chk("relock_valid_drop", bus.word_valid_o, 0);
    chk("relock_no_calib_yet", bus.calib_o, 0);
    wait_lock("relock", t);
    chk("relock_pulses", pulse_cnt - p0, 1);
    chk("relock_slip", bus.slip_cnt_o, 1);

    // en_i low together with relock_i: straight to IDLE, slip count kept.
    p0 = pulse_cnt;
    bus.en_i = 1'b0;
    bus.relock_i = 1'b1;
    tick();
    bus.relock_i = 1'b0;
    chk("dis_locked", bus.locked_o, 0);
    chk("dis_valid", bus.word_valid_o, 0);
    chk("dis_calib", bus.calib_o, 0);
    chk("dis_slip_kept", bus.slip_cnt_o, 1);
    repeat (8) tick();
    chk("dis_no_pulses", pulse_cnt - p0, 0);
    chk("dis_still_unlocked", bus.locked_o, 0);
    chk("dis_slip_still", bus.slip_cnt_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
